bf16_acc: RTL and testbench

- Accumulates the stream of bfloat16 products from the FPU's combinational bf16 multiplier into a running bfloat16 sum. Together they form a dot-product / MAC path.
- Sits directly downstream of the multiplier output. Takes one product per valid/ready handshake and emits the sum when a term is marked last.
- Multi-cycle FSM with one add in flight; the accumulator feeds back into itself, so there is no overlap between terms.

---
 rtl/bf16_acc_if.sv | 41 ++++
 rtl/bf16_acc.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_bf16_acc.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bf16_acc_if.sv
// Handshake bundle for the bf16 product accumulator.
// Input stream: products with valid/ready and a last marker.
// Output stream: finished sums with their term count.
// The sideband clear_i aborts the sum being built.
// Optional macro FPU_ACC_STATUS_EN adds the status_o exception flags.
interface bf16_acc_if #(
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [15:0]      in_data_i;
    logic             in_last_i;
    logic             clear_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [15:0]      out_data_o;
    logic [CNT_W-1:0] out_count_o;
`ifdef FPU_ACC_STATUS_EN
    logic [2:0]       status_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_count_o, status_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_count_o, status_o
    );
`else
    modport master (
        output in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_count_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_count_o
    );
`endif
endinterface

// File: rtl/bf16_acc.sv
// bfloat16 running-sum accumulator fed by the bf16 multiplier.
// Each accepted term goes through ACC -> ALIGN -> ADD, with one add in flight.
// A term marked last, or the AUTO_LAST-th term, routes the sum to OUT.
// Subnormals are flushed to zero, rounding is nearest-even, and NaN is sticky.
// Optional macro FPU_ACC_STATUS_EN adds status_o = {invalid, overflow, inexact}.
module bf16_acc #(
    parameter int CNT_W     = 8,
    parameter int AUTO_LAST = 0
) (
    input logic       clk_i,
    input logic       rst_i,
    bf16_acc_if.slave bus
);
    typedef enum logic [1:0] {ACC, ALIGN, ADD, OUT} state_t;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        inx;
    } rnd_t;

    localparam logic [15:0]      QNAN    = 16'h7FC0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic is_nan(input logic [14:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    function automatic logic is_inf(input logic [14:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
    endfunction

    // Zero-exponent operands become signed zero.
    function automatic logic [15:0] flush(input logic [15:0] x);
        return (x[14:7] == 8'd0) ? {x[15], 15'd0} : x;
    endfunction

    // Right-shift an 8-bit significand into {sig, G, R, S}.
    // Shifted-out bits are folded into the sticky bit.
    function automatic logic [10:0] align_shift(input logic [7:0] sig, input logic [7:0] diff);
        logic [21:0] wide;
        logic [10:0] r;
        if (diff >= 8'd11) begin
            r = {10'd0, |sig};
        end else begin
            wide = {sig, 14'd0} >> diff;
            r    = wide[21:11];
            r[0] = r[0] | (|wide[10:0]);
        end
        return r;
    endfunction

    // Round a normalized {1.frac, G, R, S} to nearest-even.
    // Saturates to signed Inf on overflow and flushes to signed zero on underflow.
    function automatic rnd_t round_pack(input logic sign, input logic signed [9:0] exp_n,
                                        input logic [10:0] m);
        rnd_t              r;
        logic              rnd_up;
        logic [7:0]        mant;
        logic signed [9:0] exp_r;
        r      = '0;
        rnd_up = m[2] & (m[1] | m[0] | m[3]);
        mant   = {1'b0, m[9:3]} + {7'd0, rnd_up};
        exp_r  = mant[7] ? (exp_n + 10'sd1) : exp_n;
        r.inx  = |m[2:0];
        if ((exp_n < 10'sd1) || !m[10]) begin
            r.res = {sign, 15'd0};
            r.inx = 1'b1;
        end else if (exp_r >= 10'sd255) begin
            r.res = {sign, 15'h7F80};
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else begin
            r.res = {sign, exp_r[7:0], mant[6:0]};
        end
        return r;
    endfunction

    state_t           state;
    logic [15:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             rdy_q;
    logic             vld_q;
    logic             accept;
    logic             auto_last;

    // Operand captured at the handshake.
    logic [15:0]      op_p0;

    // Aligned operands and special-case result.
    logic             sign_big_p1;
    logic [7:0]       exp_big_p1;
    logic [7:0]       sig_big_p1;
    logic [10:0]      sml_p1;
    logic             sub_p1;
    logic             spec_p1;
    logic [15:0]      spec_res_p1;
    logic             spec_inv_p1;

    // Combinational alignment from the accumulator and the latched operand.
    logic [15:0]      a_f, b_f, big, sml;
    logic             a_nan, b_nan, a_inf, b_inf, nan_res;
    logic [7:0]       diff;

    // Combinational add, normalize and round.
    logic [11:0]       sum_s;
    logic [10:0]       norm_m;
    logic signed [9:0] norm_e;
    logic [3:0]        lz;
    logic              found;
    rnd_t              rnd;
    logic [15:0]       add_res;
    logic              add_inv, add_ovf, add_inx;

    assign accept    = (state == ACC) && rdy_q && bus.in_valid_i;
    assign auto_last = (AUTO_LAST != 0) && ((int'(cnt_q) + 1) == AUTO_LAST);

    assign bus.in_ready_o  = rdy_q;
    assign bus.out_valid_o = vld_q;
    assign bus.out_data_o  = acc_q;
    assign bus.out_count_o = cnt_q;

    // Order the operands by magnitude and classify specials.
    always_comb begin
        a_f     = flush(acc_q);
        b_f     = flush(op_p0);
        a_nan   = is_nan(a_f[14:0]);
        b_nan   = is_nan(b_f[14:0]);
        a_inf   = is_inf(a_f[14:0]);
        b_inf   = is_inf(b_f[14:0]);
        nan_res = a_nan || b_nan || (a_inf && b_inf && (a_f[15] != b_f[15]));
        big     = (b_f[14:0] > a_f[14:0]) ? b_f : a_f;
        sml     = (b_f[14:0] > a_f[14:0]) ? a_f : b_f;
        diff    = big[14:7] - sml[14:7];
    end

    // Capture the operand at the handshake.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_p0 <= bus.in_data_i;
        end
    end

    // ALIGN -> ADD boundary
    always_ff @(posedge clk_i) begin
        if (state == ALIGN) begin
            sign_big_p1 <= big[15];
            exp_big_p1  <= big[14:7];
            sig_big_p1  <= {|big[14:7], big[6:0]};
            sml_p1      <= align_shift({|sml[14:7], sml[6:0]}, diff);
            sub_p1      <= big[15] ^ sml[15];
            spec_p1     <= nan_res || a_inf || b_inf;
            spec_res_p1 <= nan_res ? QNAN : (a_inf ? {a_f[15], 15'h7F80} : {b_f[15], 15'h7F80});
            spec_inv_p1 <= nan_res;
        end
    end

    // Magnitude add or subtract, normalize, then round.
    always_comb begin
        if (sub_p1) begin
            sum_s = {1'b0, sig_big_p1, 3'b000} - {1'b0, sml_p1};
        end else begin
            sum_s = {1'b0, sig_big_p1, 3'b000} + {1'b0, sml_p1};
        end
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (!found) begin
                if (sum_s[i]) begin
                    found = 1'b1;
                end else begin
                    lz = lz + 4'd1;
                end
            end
        end
        if (sum_s[11]) begin
            norm_m = {sum_s[11:2], sum_s[1] | sum_s[0]};
            norm_e = signed'({2'b00, exp_big_p1}) + 10'sd1;
        end else begin
            norm_m = sum_s[10:0] << lz;
            norm_e = signed'({2'b00, exp_big_p1}) - signed'({6'd0, lz});
        end
        rnd     = round_pack(sign_big_p1, norm_e, norm_m);
        add_res = rnd.res;
        add_ovf = rnd.ovf;
        add_inx = rnd.inx;
        add_inv = 1'b0;
        if (spec_p1) begin
            add_res = spec_res_p1;
            add_ovf = 1'b0;
            add_inx = 1'b0;
            add_inv = spec_inv_p1;
        end else if (sum_s == 12'd0) begin
            add_res = 16'h0000;
            add_ovf = 1'b0;
            add_inx = 1'b0;
        end
    end

    // Control FSM: accumulator, term count, handshake flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ACC;
            acc_q  <= 16'h0000;
            cnt_q  <= '0;
            last_q <= 1'b0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (bus.clear_i) begin
            state  <= ACC;
            acc_q  <= 16'h0000;
            cnt_q  <= '0;
            last_q <= 1'b0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        last_q <= bus.in_last_i || auto_last;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        rdy_q  <= 1'b0;
                        state  <= ALIGN;
                    end else begin
                        rdy_q  <= 1'b1;
                    end
                end
                ALIGN: begin
                    state <= ADD;
                end
                ADD: begin
                    acc_q <= add_res;
                    if (last_q) begin
                        vld_q <= 1'b1;
                        state <= OUT;
                    end else begin
                        rdy_q <= 1'b1;
                        state <= ACC;
                    end
                end
                OUT: begin
                    if (bus.out_ready_i) begin
                        acc_q <= 16'h0000;
                        cnt_q <= '0;
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

`ifdef FPU_ACC_STATUS_EN
    logic [2:0] flags_q;

    // Sticky per-sum exception flags, dropped when the sum leaves or is aborted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= 3'b000;
        end else if (bus.clear_i) begin
            flags_q <= 3'b000;
        end else if ((state == OUT) && bus.out_ready_i) begin
            flags_q <= 3'b000;
        end else if (state == ADD) begin
            flags_q <= flags_q | {add_inv, add_ovf, add_inx};
        end
    end

    assign bus.status_o = flags_q;
`else
    // The exception flags have no consumer without the status output.
    logic unused_flags;
    assign unused_flags = ^{add_inv, add_ovf, add_inx};
`endif
endmodule

// File: tb/tb_bf16_acc.sv
// Directed bench for bf16_acc.
// Expected sums are queued when stimulus is driven and checked when the result appears.
// With FPU_ACC_STATUS_EN defined, status_o is checked as well.
module tb_bf16_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   lat;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  c;
        logic [2:0]  st;
    } exp_t;

    exp_t sb_q[$];

    bf16_acc_if #(.CNT_W(8)) bus ();

    bf16_acc #(.CNT_W(8), .AUTO_LAST(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_sum(input logic [15:0] d, input logic [7:0] c, input logic [2:0] st);
        exp_t e;
        e.d  = d;
        e.c  = c;
        e.st = st;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_last_i  = l;
        while (!bus.in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.out_valid_o) break;
        end
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    endtask

    task automatic recv(input string tag, output int n);
        exp_t e;
        e.d  = 16'hDEAD;
        e.c  = 8'hFF;
        e.st = 3'b111;
        wait_valid(tag, n);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        check({tag, "_data"}, 32'(bus.out_data_o), 32'(e.d));
        check({tag, "_count"}, 32'(bus.out_count_o), 32'(e.c));
`ifdef FPU_ACC_STATUS_EN
        check({tag, "_status"}, 32'(bus.status_o), 32'(e.st));
`endif
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 16'h0000;
        bus.in_last_i   = 1'b0;
        bus.clear_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        // Outputs held at zero while reset is asserted.
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_data",  32'(bus.out_data_o),  32'h0000);
        check("rst_count", 32'(bus.out_count_o), 32'd0);
        check("rst_ready", 32'(bus.in_ready_o),  32'd0);
        rst = 1'b0;

        // 1.0 + 2.0 = 3.0, result three cycles after the last accept.
        expect_sum(16'h4040, 8'd2, 3'b000);
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        recv("add3", lat);
        check("latency", 32'(lat), 32'd3);

        // Exact cancellation gives +0.
        expect_sum(16'h0000, 8'd2, 3'b000);
        send(16'h3F80, 1'b0);
        send(16'hBF80, 1'b1);
        recv("cancel", lat);

        // 256 + 1.5 = 257.5 rounds up to 258.
        expect_sum(16'h4381, 8'd2, 3'b001);
        send(16'h4380, 1'b0);
        send(16'h3FC0, 1'b1);
        recv("rnd_up", lat);

        // 256 + 1 = 257 is a tie and stays at the even 256.
        expect_sum(16'h4380, 8'd2, 3'b001);
        send(16'h4380, 1'b0);
        send(16'h3F80, 1'b1);
        recv("tie_even", lat);

        // +Inf plus -Inf gives the canonical NaN.
        expect_sum(16'h7FC0, 8'd2, 3'b100);
        send(16'h7F80, 1'b0);
        send(16'hFF80, 1'b1);
        recv("inf_nan", lat);

        // Largest finite value doubled overflows to +Inf.
        expect_sum(16'h7F80, 8'd2, 3'b011);
        send(16'h7F7F, 1'b0);
        send(16'h7F7F, 1'b1);
        recv("ovf", lat);

        // Result holds while the consumer stalls.
        expect_sum(16'h4040, 8'd2, 3'b000);
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        wait_valid("hold", lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_data",  32'(bus.out_data_o), 32'h4040);
            check("hold_ready", 32'(bus.in_ready_o), 32'd0);
        end
        recv("hold_rel", lat);

        // After release the next sum starts from +0.
        expect_sum(16'h3F00, 8'd1, 3'b000);
        send(16'h3F00, 1'b1);
        recv("fresh", lat);

        // The fourth term closes the sum without in_last_i.
        expect_sum(16'h4080, 8'd4, 3'b000);
        for (int k = 0; k < 4; k++) send(16'h3F80, 1'b0);
        recv("auto_last", lat);

        // Reset while the second term is in ALIGN.
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid_o), 32'd0);
        check("arst_data",  32'(bus.out_data_o),  32'h0000);
        check("arst_count", 32'(bus.out_count_o), 32'd0);
        check("arst_ready", 32'(bus.in_ready_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("arst_noout", 32'(bus.out_valid_o), 32'd0);

        // Clear in OUT drops the pending result.
        send(16'h4000, 1'b1);
        wait_valid("clr_out", lat);
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        check("clr_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("clr_out_count", 32'(bus.out_count_o), 32'd0);
        expect_sum(16'h3F00, 8'd1, 3'b000);
        send(16'h3F00, 1'b1);
        recv("clr_next", lat);

        // Clear wins over a same-cycle handshake in ACC.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 16'h4000;
        bus.in_last_i  = 1'b1;
        bus.clear_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.clear_i    = 1'b0;
        check("clr_acc_ready", 32'(bus.in_ready_o),  32'd1);
        check("clr_acc_count", 32'(bus.out_count_o), 32'd0);
        expect_sum(16'h3F80, 8'd1, 3'b000);
        send(16'h3F80, 1'b1);
        recv("clr_acc_next", lat);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
